// File: rtl/pipeline_stall_ctrl_pkg.sv
// riscie_pipe_pkg: shared types for the pipeline sequencer.
//   pipe_state_e  - sequencer FSM states
//   REG_X0        - architectural zero register index (never a hazard source)
//   pipe_ctrl_t   - the seven stage-register control outputs
//   DEFAULT_CTRL  - free-running pipeline (all enables on, no flush/bubble)
//   FREEZE_CTRL   - data-memory wait: hold PC..EX/MEM, bubble into MEM/WB
package riscie_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } pipe_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t DEFAULT_CTRL = '{
        pc_write:    1'b1,
        ifid_write:  1'b1,
        ifid_flush:  1'b0,
        idex_write:  1'b1,
        idex_bubble: 1'b0,
        exmem_write: 1'b1,
        memwb_bubble: 1'b0
    };

    localparam pipe_ctrl_t FREEZE_CTRL = '{
        pc_write:    1'b0,
        ifid_write:  1'b0,
        ifid_flush:  1'b0,
        idex_write:  1'b0,
        idex_bubble: 1'b0,
        exmem_write: 1'b0,
        memwb_bubble: 1'b1
    };

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard inputs and pipe-control outputs of the
// pipeline sequencer.
//   slave  - the sequencer (consumes hazard info, drives controls)
//   master - the datapath side (drives hazard info, consumes controls)
interface pipeline_stall_ctrl_if;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        ifid_use_rs1;
    logic        ifid_use_rs2;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        dmem_ready;
    logic        imem_ready;

    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_bubble;
    logic        exmem_write;
    logic        memwb_bubble;
    logic        mem_err;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    modport slave (
        input  idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1,
               ifid_use_rs2, ex_branch_taken, mem_req, dmem_ready, imem_ready,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_write, memwb_bubble, mem_err, perf_stall_cnt, perf_flush_cnt
    );

    modport master (
        output idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1,
               ifid_use_rs2, ex_branch_taken, mem_req, dmem_ready, imem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_write, memwb_bubble, mem_err, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the
// instruction in ID. x0 never hazards.
//   idex_mem_read_i, idex_rd_i            - EX instruction info
//   ifid_rs1_i/rs2_i, ifid_use_rs1_i/rs2_i - ID source operands and usage
//   luse_o                                 - load-use hazard
module load_use_detect
    import riscie_pipe_pkg::*;
(
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rd_i,
    input  logic [4:0] ifid_rs1_i,
    input  logic [4:0] ifid_rs2_i,
    input  logic       ifid_use_rs1_i,
    input  logic       ifid_use_rs2_i,
    output logic       luse_o
);
    assign luse_o = idex_mem_read_i && (idex_rd_i != REG_X0) &&
                    ((ifid_use_rs1_i && (idex_rd_i == ifid_rs1_i)) ||
                     (ifid_use_rs2_i && (idex_rd_i == ifid_rs2_i)));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush sequencer for the 5-stage core.
// Merges load-use, taken-branch and memory-wait hazards into stage-register
// enables; controls are Mealy so a stall acts in the cycle it is seen.
//   clk, rst_n - core clock, async active-low reset
//   pif        - hazard inputs / pipe controls, mem_err, perf counters
// Optional: PIPE_PERF_CNT_EN builds the stall/flush performance counters;
// otherwise both counter outputs are tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue; hazards resolved by priority mem > branch > luse > fetch
// MEM_WAIT | dmem busy, pipeline frozen, timeout counter running
// REDIRECT | branch target fetch outstanding, PC holds target, IF/ID flushed
module pipeline_stall_ctrl
    import riscie_pipe_pkg::*;
#(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    pipeline_stall_ctrl_if.slave pif
);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX     = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] CNT_ONE     = TIMEOUT_W'(1);

    pipe_state_e          state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 mem_err_q, mem_err_d;
    pipe_ctrl_t           ctrl;
    logic                 luse;
    logic                 mem_stall;

    load_use_detect u_luse (
        .idex_mem_read_i (pif.idex_mem_read),
        .idex_rd_i       (pif.idex_rd),
        .ifid_rs1_i      (pif.ifid_rs1),
        .ifid_rs2_i      (pif.ifid_rs2),
        .ifid_use_rs1_i  (pif.ifid_use_rs1),
        .ifid_use_rs2_i  (pif.ifid_use_rs2),
        .luse_o          (luse)
    );

    assign mem_stall = pif.mem_req && !pif.dmem_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = DEFAULT_CTRL;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    ctrl    = FREEZE_CTRL;
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (pif.ex_branch_taken) begin
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                    if (!pif.imem_ready) state_d = REDIRECT;
                end else if (luse) begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                end else if (!pif.imem_ready) begin
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branch/luse are not looked at: EX is frozen and they are
                // re-evaluated once the pipeline is back in RUN.
                if (pif.dmem_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    ctrl = FREEZE_CTRL;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                end
            end
            REDIRECT: begin
                if (mem_stall) begin
                    ctrl    = FREEZE_CTRL;
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (pif.imem_ready) begin
                    // Target fetch is valid now; let it enter IF/ID.
                    state_d = RUN;
                end else begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        if (!rst_n) ctrl = DEFAULT_CTRL;
    end

    assign mem_err_d = mem_err_q || ((state_q == MEM_WAIT) && (cnt_q == TIMEOUT_VAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign pif.pc_write     = ctrl.pc_write;
    assign pif.ifid_write   = ctrl.ifid_write;
    assign pif.ifid_flush   = ctrl.ifid_flush;
    assign pif.idex_write   = ctrl.idex_write;
    assign pif.idex_bubble  = ctrl.idex_bubble;
    assign pif.exmem_write  = ctrl.exmem_write;
    assign pif.memwb_bubble = ctrl.memwb_bubble;
    assign pif.mem_err      = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        flush_evt;

    // A redirect is counted only when RUN actually acts on the branch.
    assign flush_evt = (state_q == RUN) && !mem_stall && pif.ex_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctrl.pc_write) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_evt)      flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign pif.perf_stall_cnt = stall_cnt_q;
    assign pif.perf_flush_cnt = flush_cnt_q;
`else
    assign pif.perf_stall_cnt = 32'd0;
    assign pif.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (MEM_TIMEOUT reduced to 10).
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
module tb_pipeline_stall_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble}
    localparam logic [6:0] DEF_V   = 7'b1101010;
    localparam logic [6:0] FRZ_V   = 7'b0000001;
    localparam logic [6:0] LUSE_V  = 7'b0001110;
    localparam logic [6:0] BR_V    = 7'b1111110;
    localparam logic [6:0] REDIR_V = 7'b0111110;
    localparam logic [6:0] FETCH_V = 7'b0111010;

    pipeline_stall_ctrl_if pif ();

    pipeline_stall_ctrl #(.TIMEOUT_W(8), .MEM_TIMEOUT(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] perf_exp(input int v);
`ifdef PIPE_PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the control vector for the current cycle and advances one clock.
    task automatic step(input string tag, input logic [6:0] exp);
        logic [6:0] got;
        #2;
        got = {pif.pc_write, pif.ifid_write, pif.ifid_flush, pif.idex_write,
               pif.idex_bubble, pif.exmem_write, pif.memwb_bubble};
        chk(tag, 32'(got), 32'(exp));
        if (rst_n && !exp[6]) exp_stall++;
        if (rst_n && exp == BR_V) exp_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pif.idex_mem_read   = 1'b0;
        pif.idex_rd         = 5'd0;
        pif.ifid_rs1        = 5'd0;
        pif.ifid_rs2        = 5'd0;
        pif.ifid_use_rs1    = 1'b0;
        pif.ifid_use_rs2    = 1'b0;
        pif.ex_branch_taken = 1'b0;
        pif.mem_req         = 1'b0;
        pif.dmem_ready      = 1'b1;
        pif.imem_ready      = 1'b1;
    endtask

    initial begin
        idle();
        // Reset with a hazard present: outputs must still be the default set.
        pif.mem_req = 1'b1; pif.dmem_ready = 1'b0;
        #2;
        chk("rst_ctrl", 32'({pif.pc_write, pif.ifid_write, pif.ifid_flush, pif.idex_write,
                             pif.idex_bubble, pif.exmem_write, pif.memwb_bubble}), 32'(DEF_V));
        chk("rst_mem_err", 32'(pif.mem_err), 32'd0);
        chk("rst_perf_stall", pif.perf_stall_cnt, 32'd0);
        chk("rst_perf_flush", pif.perf_flush_cnt, 32'd0);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;

        step("idle", DEF_V);

        // Load-use on rs2, then the bubble removes the load from the compare.
        pif.idex_mem_read = 1'b1; pif.idex_rd = 5'd5; pif.ifid_rs2 = 5'd5; pif.ifid_use_rs2 = 1'b1;
        step("luse_rs2", LUSE_V);
        pif.idex_mem_read = 1'b0;
        step("luse_done", DEF_V);
        pif.idex_mem_read = 1'b1; pif.idex_rd = 5'd7; pif.ifid_rs1 = 5'd7; pif.ifid_use_rs1 = 1'b1;
        step("luse_rs1", LUSE_V);
        idle();
        pif.idex_mem_read = 1'b1; pif.idex_rd = 5'd5; pif.ifid_rs2 = 5'd5; pif.ifid_use_rs2 = 1'b0;
        step("luse_unused_rs2", DEF_V);
        pif.idex_rd = 5'd0; pif.ifid_rs1 = 5'd0; pif.ifid_use_rs1 = 1'b1;
        step("luse_x0", DEF_V);
        idle();

        // Taken branch with fetch ready: one flush cycle.
        chk("flush_before", pif.perf_flush_cnt, perf_exp(0));
        pif.ex_branch_taken = 1'b1;
        step("br_ready", BR_V);
        pif.ex_branch_taken = 1'b0;
        step("br_after", DEF_V);
        chk("flush_after_br", pif.perf_flush_cnt, perf_exp(1));

        // Taken branch with fetch missing for 3 cycles.
        pif.ex_branch_taken = 1'b1; pif.imem_ready = 1'b0;
        step("redir_c0", BR_V);
        pif.ex_branch_taken = 1'b0;
        step("redir_c1", REDIR_V);
        step("redir_c2", REDIR_V);
        pif.imem_ready = 1'b1;
        step("redir_exit", DEF_V);
        pif.imem_ready = 1'b0;
        step("run_fetch_stall", FETCH_V);
        pif.imem_ready = 1'b1;
        step("run_after_fetch", DEF_V);

        // Dmem wait for 4 cycles with branch and load-use pending.
        pif.mem_req = 1'b1; pif.dmem_ready = 1'b0; pif.ex_branch_taken = 1'b1;
        pif.idex_mem_read = 1'b1; pif.idex_rd = 5'd3; pif.ifid_rs1 = 5'd3; pif.ifid_use_rs1 = 1'b1;
        step("mw_c0", FRZ_V);
        step("mw_c1", FRZ_V);
        step("mw_c2", FRZ_V);
        step("mw_c3", FRZ_V);
        pif.dmem_ready = 1'b1;
        step("mw_ready", DEF_V);
        pif.mem_req = 1'b0; pif.idex_mem_read = 1'b0;
        step("mw_branch_deferred", BR_V);
        idle();
        pif.idex_mem_read = 1'b1; pif.idex_rd = 5'd3; pif.ifid_rs1 = 5'd3; pif.ifid_use_rs1 = 1'b1;
        step("mw_luse_deferred", LUSE_V);
        idle();
        step("mw_idle", DEF_V);
        chk("perf_stall_mid", pif.perf_stall_cnt, perf_exp(exp_stall));

        // Memory stall arriving while in REDIRECT.
        pif.ex_branch_taken = 1'b1; pif.imem_ready = 1'b0;
        step("rm_br", BR_V);
        pif.ex_branch_taken = 1'b0; pif.mem_req = 1'b1; pif.dmem_ready = 1'b0;
        step("rm_freeze", FRZ_V);
        pif.dmem_ready = 1'b1;
        step("rm_ready", DEF_V);
        idle();
        step("rm_idle", DEF_V);

        // Timeout: counter is 1 on the first wait cycle, flag follows count==10.
        pif.mem_req = 1'b1; pif.dmem_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) chk("mem_err_pre", 32'(pif.mem_err), 32'd0);
            step("to_freeze", FRZ_V);
        end
        #2;
        chk("mem_err_set", 32'(pif.mem_err), 32'd1);
        pif.dmem_ready = 1'b1;
        step("to_ready", DEF_V);
        idle();
        pif.ex_branch_taken = 1'b1;
        step("to_traffic", BR_V);
        idle();
        step("to_idle", DEF_V);
        #2;
        chk("mem_err_sticky", 32'(pif.mem_err), 32'd1);
        chk("perf_stall_end", pif.perf_stall_cnt, perf_exp(exp_stall));
        chk("perf_flush_end", pif.perf_flush_cnt, perf_exp(exp_flush));
        @(posedge clk); #1;

        // Reset in the middle of a memory wait.
        pif.mem_req = 1'b1; pif.dmem_ready = 1'b0;
        step("rw_c0", FRZ_V);
        step("rw_c1", FRZ_V);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_ctrl", 32'({pif.pc_write, pif.ifid_write, pif.ifid_flush, pif.idex_write,
                            pif.idex_bubble, pif.exmem_write, pif.memwb_bubble}), 32'(DEF_V));
        chk("rw_mem_err", 32'(pif.mem_err), 32'd0);
        chk("rw_perf_stall", pif.perf_stall_cnt, 32'd0);
        chk("rw_perf_flush", pif.perf_flush_cnt, 32'd0);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("rw_after", DEF_V);
        chk("rw_mem_err_after", 32'(pif.mem_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
